laser_sweep_obstacle: RTL and testbench



---
 rtl/laser_sweep_obstacle_pkg.sv | 25 ++
 rtl/laser_sweep_obstacle_if.sv | 29 ++
 rtl/laser_sweep_obstacle_timer.sv | 72 +++++++
 rtl/laser_sweep_obstacle.sv | 177 +++++++++++++++++
 tb/tb_laser_sweep_obstacle.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/laser_sweep_obstacle_pkg.sv
// Shared types and constants for the laser sweep obstacle.
//   state_e  : sweep FSM encoding (IDLE / GROW / HOLD)
//   color_t  : 12-bit RGB pixel colour
//   LASER_TOP_DEF / LASER_BOTTOM_DEF : default vertical laser extent on screen
//   laser_base() : left core column of a given laser index
package obstacle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GROW = 2'd1,
        HOLD = 2'd2
    } state_e;

    typedef logic [11:0] color_t;

    localparam int LASER_TOP_DEF    = 317;
    localparam int LASER_BOTTOM_DEF = 617;

    // base_i = first_x + i*spacing, truncated to screen coordinate width
    function automatic logic [11:0] laser_base(input int first_x, input int spacing,
                                               input logic [2:0] idx);
        return 12'(first_x + int'(idx) * spacing);
    endfunction

endpackage

// File: rtl/laser_sweep_obstacle_if.sv
// Pixel/control bundle between the video pipeline and the laser sweep block.
//   master : drives pixel position/colour and start/abort, observes results
//   slave  : the laser sweep block itself
interface laser_sweep_obstacle_if;
    import obstacle_pkg::*;

    logic [11:0] hcount_in;
    logic [11:0] vcount_in;
    color_t      rgb_in;
    logic        start;
    logic        abort;
    color_t      rgb_out;
    logic [11:0] obstacle_x;
    logic [11:0] obstacle_y;
    logic [2:0]  laser_idx;
    logic        working;
    logic        done;

    modport master (
        output hcount_in, vcount_in, rgb_in, start, abort,
        input  rgb_out, obstacle_x, obstacle_y, laser_idx, working, done
    );

    modport slave (
        input  hcount_in, vcount_in, rgb_in, start, abort,
        output rgb_out, obstacle_x, obstacle_y, laser_idx, working, done
    );

endinterface

// File: rtl/laser_sweep_obstacle_timer.sv
// laser_phase_timer: grow/hold tick counters and the laser half-width.
//   pclk, rst     : pixel clock, async active-high reset
//   clr_i         : zero counters and half-width (idle, step change, abort)
//   grow_i/hold_i : FSM is in GROW / HOLD
//   hw_o          : current half-width growth
//   grow_done_o   : last grow tick of the final pixel step (hw about to hit MAX_HW)
//   step_done_o   : last hold tick of the current step
module laser_phase_timer #(
    parameter int GROW_TICKS = 3200000,
    parameter int HOLD_TICKS = 32000000,
    parameter int MAX_HW     = 30,
    parameter int HW_W       = $clog2(MAX_HW + 1)
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            grow_i,
    input  logic            hold_i,
    output logic [HW_W-1:0] hw_o,
    output logic            grow_done_o,
    output logic            step_done_o
);

    localparam int GW = (GROW_TICKS > 1) ? $clog2(GROW_TICKS) : 1;
    localparam int HDW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic [GW-1:0]   grow_cnt_q, grow_cnt_d;
    logic [HDW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [HW_W-1:0] hw_q, hw_d;
    logic            grow_last, hold_last;

    assign grow_last   = (grow_cnt_q == GW'(GROW_TICKS - 1));
    assign hold_last   = (hold_cnt_q == HDW'(HOLD_TICKS - 1));
    assign grow_done_o = grow_i && grow_last && (hw_q == HW_W'(MAX_HW - 1));
    assign step_done_o = hold_i && hold_last;
    assign hw_o        = hw_q;

    // hw stops at MAX_HW because the FSM leaves GROW on that same tick,
    // so neither counter nor hw can wrap.
    always_comb begin
        grow_cnt_d = grow_cnt_q;
        hold_cnt_d = hold_cnt_q;
        hw_d       = hw_q;
        if (clr_i) begin
            grow_cnt_d = '0;
            hold_cnt_d = '0;
            hw_d       = '0;
        end else if (grow_i) begin
            if (grow_last) begin
                grow_cnt_d = '0;
                hw_d       = hw_q + HW_W'(1);
            end else begin
                grow_cnt_d = grow_cnt_q + GW'(1);
            end
        end else if (hold_i) begin
            hold_cnt_d = hold_last ? '0 : hold_cnt_q + HDW'(1);
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            grow_cnt_q <= '0;
            hold_cnt_q <= '0;
            hw_q       <= '0;
        end else begin
            grow_cnt_q <= grow_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            hw_q       <= hw_d;
        end
    end

endmodule

// File: rtl/laser_sweep_obstacle.sv
// laser_sweep_obstacle: sweeps a row of vertical laser columns that grow,
// hold and advance, overlaying them on the pixel stream and reporting the
// coordinates of every laser pixel as an obstacle.
//   pclk, rst : pixel clock, async active-high reset
//   bus       : slave side of laser_sweep_obstacle_if
//               in : hcount_in, vcount_in, rgb_in, start (pulse), abort (level)
//               out: rgb_out, obstacle_x/y (1-cycle latency), laser_idx,
//                    working, done (1-cycle pulse)
module laser_sweep_obstacle import obstacle_pkg::*; #(
    parameter int     N_LASERS     = 3,
    parameter int     FIRST_X      = 411,
    parameter int     SPACING      = 100,
    parameter int     LASER_TOP    = LASER_TOP_DEF,
    parameter int     LASER_BOTTOM = LASER_BOTTOM_DEF,
    parameter int     MAX_HW       = 30,
    parameter int     GROW_TICKS   = 3200000,
    parameter int     HOLD_TICKS   = 32000000,
    parameter int     BOUNCE       = 1,
    parameter color_t COLOR        = 12'hfff
) (
    input logic                  pclk,
    input logic                  rst,
    laser_sweep_obstacle_if.slave bus
);

    localparam int NSTEPS = (BOUNCE != 0) ? 2 * N_LASERS : N_LASERS;
    localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam int HW_W   = $clog2(MAX_HW + 1);

    if (N_LASERS < 1 || N_LASERS > 8) begin : g_bad_n
        $error("laser_sweep_obstacle: N_LASERS must be 1..8");
    end
    if (FIRST_X <= MAX_HW) begin : g_bad_left
        $error("laser_sweep_obstacle: FIRST_X must exceed MAX_HW");
    end
    if (FIRST_X + (N_LASERS - 1) * SPACING + 1 + MAX_HW >= 4096) begin : g_bad_right
        $error("laser_sweep_obstacle: rightmost laser exceeds 12-bit range");
    end
    if (MAX_HW < 1 || GROW_TICKS < 1 || HOLD_TICKS < 1) begin : g_bad_time
        $error("laser_sweep_obstacle: MAX_HW, GROW_TICKS, HOLD_TICKS must be >= 1");
    end

    state_e          state_q;
    logic [SW-1:0]   step_q;
    logic [SW-1:0]   step_nxt;
    logic [2:0]      idx_q;
    logic            working_q;
    logic            done_q;
    color_t          rgb_q;
    logic [11:0]     ox_q, oy_q;

    logic [HW_W-1:0] hw;
    logic            grow_done, step_done, tmr_clr;

    // Forward steps map straight to lasers; reverse steps mirror, so the
    // last laser is visited twice in a row when bouncing.
    function automatic logic [2:0] step_laser(input logic [SW-1:0] s);
        if (int'(s) < N_LASERS) return 3'(s);
        return 3'(2 * N_LASERS - 1 - int'(s));
    endfunction

    assign step_nxt = step_q + SW'(1);
    assign tmr_clr  = (state_q == IDLE) || step_done || bus.abort;

    laser_phase_timer #(
        .GROW_TICKS (GROW_TICKS),
        .HOLD_TICKS (HOLD_TICKS),
        .MAX_HW     (MAX_HW),
        .HW_W       (HW_W)
    ) u_timer (
        .pclk        (pclk),
        .rst         (rst),
        .clr_i       (tmr_clr),
        .grow_i      (state_q == GROW),
        .hold_i      (state_q == HOLD),
        .hw_o        (hw),
        .grow_done_o (grow_done),
        .step_done_o (step_done)
    );

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            idx_q     <= '0;
            working_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_q   <= GROW;
                        step_q    <= '0;
                        idx_q     <= '0;
                        working_q <= 1'b1;
                    end
                end
                GROW: begin
                    if (bus.abort) begin
                        state_q   <= IDLE;
                        step_q    <= '0;
                        idx_q     <= '0;
                        working_q <= 1'b0;
                    end else if (grow_done) begin
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.abort) begin
                        state_q   <= IDLE;
                        step_q    <= '0;
                        idx_q     <= '0;
                        working_q <= 1'b0;
                    end else if (step_done) begin
                        if (step_q == SW'(NSTEPS - 1)) begin
                            state_q   <= IDLE;
                            step_q    <= '0;
                            idx_q     <= '0;
                            working_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            state_q <= GROW;
                            step_q  <= step_nxt;
                            idx_q   <= step_laser(step_nxt);
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    step_q    <= '0;
                    idx_q     <= '0;
                    working_q <= 1'b0;
                end
            endcase
        end
    end

    // Hit test against the laser as it stands this cycle; base-hw cannot
    // underflow and base+1+hw cannot overflow given the elaboration checks.
    logic [11:0] base, lo, hi;
    logic        in_laser;

    always_comb begin
        base     = laser_base(FIRST_X, SPACING, idx_q);
        lo       = base - 12'(hw);
        hi       = base + 12'd1 + 12'(hw);
        in_laser = working_q
                && (bus.hcount_in >= lo) && (bus.hcount_in <= hi)
                && (bus.vcount_in >= 12'(LASER_TOP))
                && (bus.vcount_in <= 12'(LASER_BOTTOM));
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
        end else if (in_laser) begin
            rgb_q <= COLOR;
            ox_q  <= bus.hcount_in;
            oy_q  <= bus.vcount_in;
        end else begin
            rgb_q <= bus.rgb_in;
            ox_q  <= '0;
            oy_q  <= '0;
        end
    end

    assign bus.rgb_out    = rgb_q;
    assign bus.obstacle_x = ox_q;
    assign bus.obstacle_y = oy_q;
    assign bus.laser_idx  = idx_q;
    assign bus.working    = working_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_laser_sweep_obstacle.sv
// Scoreboard bench for laser_sweep_obstacle: two instances (bouncing and
// forward-only) with short timing, 8 cycles per step. Stimulus pushes
// expectations tagged with the cycle they must appear; a negedge monitor
// compares them and checks every done pulse against its own queue.
module tb_laser_sweep_obstacle;
    import obstacle_pkg::*;

    localparam color_t COLOR  = 12'hfff;
    localparam color_t RGB_IN = 12'h0a5;

    typedef struct {
        int          cyc;
        bit          f;
        bit          ck_ctl;
        bit          ck_pix;
        string       name;
        logic [2:0]  idx;
        logic        wk;
        logic        dn;
        logic [11:0] rgb;
        logic [11:0] ox;
        logic [11:0] oy;
    } exp_t;

    logic pclk = 1'b0;
    logic rst  = 1'b1;
    int   cyc  = 0;
    int   total = 0;
    int   bad   = 0;
    bit   end_req = 1'b0;

    exp_t sb[$];
    int   done_b[$];
    int   done_f[$];

    laser_sweep_obstacle_if bus_b ();
    laser_sweep_obstacle_if bus_f ();

    laser_sweep_obstacle #(.N_LASERS(3), .MAX_HW(2), .GROW_TICKS(2), .HOLD_TICKS(4),
                           .BOUNCE(1), .COLOR(COLOR))
        dut_b (.pclk(pclk), .rst(rst), .bus(bus_b));

    laser_sweep_obstacle #(.N_LASERS(3), .MAX_HW(2), .GROW_TICKS(2), .HOLD_TICKS(4),
                           .BOUNCE(0), .COLOR(COLOR))
        dut_f (.pclk(pclk), .rst(rst), .bus(bus_f));

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_ctl(input bit f, input int c, input int idx, input bit wk,
                            input bit dn, input string nm);
        exp_t e;
        e.cyc = c; e.f = f; e.ck_ctl = 1'b1; e.ck_pix = 1'b0; e.name = nm;
        e.idx = 3'(idx); e.wk = wk; e.dn = dn;
        e.rgb = '0; e.ox = '0; e.oy = '0;
        sb.push_back(e);
    endtask

    task automatic push_zero(input bit f, input int c, input string nm);
        exp_t e;
        e.cyc = c; e.f = f; e.ck_ctl = 1'b1; e.ck_pix = 1'b1; e.name = nm;
        e.idx = '0; e.wk = 1'b0; e.dn = 1'b0;
        e.rgb = '0; e.ox = '0; e.oy = '0;
        sb.push_back(e);
    endtask

    // Present a pixel now; its result is due at the next negedge after the edge.
    task automatic pix(input bit f, input int h, input int v, input bit on, input string nm);
        exp_t e;
        if (f) begin
            bus_f.hcount_in = 12'(h); bus_f.vcount_in = 12'(v);
        end else begin
            bus_b.hcount_in = 12'(h); bus_b.vcount_in = 12'(v);
        end
        e.cyc = cyc + 1; e.f = f; e.ck_ctl = 1'b0; e.ck_pix = 1'b1; e.name = nm;
        e.idx = '0; e.wk = 1'b0; e.dn = 1'b0;
        e.rgb = on ? COLOR : RGB_IN;
        e.ox  = on ? 12'(h) : 12'd0;
        e.oy  = on ? 12'(v) : 12'd0;
        sb.push_back(e);
        tick();
    endtask

    task automatic check(input exp_t e);
        logic [2:0]  ai;
        logic        aw, ad;
        logic [11:0] ar, ax, ay;
        bit          ok;
        ai = e.f ? bus_f.laser_idx  : bus_b.laser_idx;
        aw = e.f ? bus_f.working    : bus_b.working;
        ad = e.f ? bus_f.done       : bus_b.done;
        ar = e.f ? bus_f.rgb_out    : bus_b.rgb_out;
        ax = e.f ? bus_f.obstacle_x : bus_b.obstacle_x;
        ay = e.f ? bus_f.obstacle_y : bus_b.obstacle_y;
        ok = 1'b1;
        if (e.ck_ctl && (ai !== e.idx || aw !== e.wk || ad !== e.dn)) ok = 1'b0;
        if (e.ck_pix && (ar !== e.rgb || ax !== e.ox || ay !== e.oy)) ok = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s cyc=%0d got idx=%0d wk=%b dn=%b rgb=%h xy=(%0d,%0d) want idx=%0d wk=%b dn=%b rgb=%h xy=(%0d,%0d) [ctl=%b pix=%b]",
                     e.name, cyc, ai, aw, ad, ar, ax, ay,
                     e.idx, e.wk, e.dn, e.rgb, e.ox, e.oy, e.ck_ctl, e.ck_pix);
        end
    endtask

    always @(negedge pclk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i]);
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                total++; bad++;
                $display("FAIL %s: due cyc=%0d not sampled, now=%0d", sb[i].name, sb[i].cyc, cyc);
                sb.delete(i);
            end
        end
        if (bus_b.done === 1'b1) begin
            total++;
            if (done_b.size() == 0) begin
                bad++;
                $display("FAIL done_b: unexpected pulse at cyc=%0d, want none", cyc);
            end else begin
                if (done_b[0] != cyc) begin
                    bad++;
                    $display("FAIL done_b: pulse at cyc=%0d, want cyc=%0d", cyc, done_b[0]);
                end
                void'(done_b.pop_front());
            end
        end
        if (bus_f.done === 1'b1) begin
            total++;
            if (done_f.size() == 0) begin
                bad++;
                $display("FAIL done_f: unexpected pulse at cyc=%0d, want none", cyc);
            end else begin
                if (done_f[0] != cyc) begin
                    bad++;
                    $display("FAIL done_f: pulse at cyc=%0d, want cyc=%0d", cyc, done_f[0]);
                end
                void'(done_f.pop_front());
            end
        end
        if (end_req) begin
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL leftover: %0d expectations unchecked, want 0", sb.size());
            end
            total++;
            if (done_b.size() + done_f.size() != 0) begin
                bad++;
                $display("FAIL missing_done: %0d pulses never seen, want 0", done_b.size() + done_f.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int seq_b[6] = '{0, 1, 2, 2, 1, 0};

        bus_b.hcount_in = '0; bus_b.vcount_in = '0; bus_b.rgb_in = RGB_IN;
        bus_b.start = 1'b0; bus_b.abort = 1'b0;
        bus_f.hcount_in = '0; bus_f.vcount_in = '0; bus_f.rgb_in = RGB_IN;
        bus_f.start = 1'b0; bus_f.abort = 1'b0;

        // reset state
        repeat (3) tick();
        push_zero(0, cyc, "rst_b");
        push_zero(1, cyc, "rst_f");
        tick();
        rst = 1'b0;
        repeat (2) tick();

        // full bouncing sweep with pixel probes
        push_ctl(0, cyc, 0, 0, 0, "pre_start");
        bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
        w = cyc;
        for (int k = 0; k < 6; k++) begin
            push_ctl(0, w + 8 * k,     seq_b[k], 1, 0, "step_first");
            push_ctl(0, w + 8 * k + 7, seq_b[k], 1, 0, "step_last");
        end
        push_ctl(0, w + 48, 0, 0, 1, "done_cyc");
        push_ctl(0, w + 49, 0, 0, 0, "done_one");
        done_b.push_back(w + 48);

        pix(0, 411, 317, 1, "l0_hw0_core");
        pix(0, 410, 317, 0, "l0_hw0_left");
        pix(0, 411, 618, 0, "below_bottom");
        pix(0, 412, 617, 1, "l0_hw1_bottom");
        pix(0, 409, 400, 1, "l0_hw2_left");
        pix(0, 408, 400, 0, "l0_hw2_outl");
        pix(0, 414, 400, 1, "l0_hw2_right");
        pix(0, 415, 400, 0, "l0_hw2_outr");
        pix(0, 511, 317, 1, "l1_hw0_core");
        pix(0, 412, 317, 0, "l0_after");
        repeat (2) tick();
        pix(0, 509, 500, 1, "l1_hw2_left");
        pix(0, 514, 500, 1, "l1_hw2_right");
        pix(0, 508, 500, 0, "l1_hw2_outl");
        pix(0, 515, 500, 0, "l1_hw2_outr");
        wait_to(w + 20);
        bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
        wait_to(w + 49);
        pix(0, 411, 317, 0, "idle_no_laser");
        repeat (2) tick();

        // abort mid-GROW of step 1, then abort beating start in IDLE
        bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
        w = cyc;
        push_ctl(0, w + 9,  1, 1, 0, "pre_abort");
        push_ctl(0, w + 10, 0, 0, 0, "post_abort");
        wait_to(w + 9);
        bus_b.abort = 1'b1; tick(); bus_b.abort = 1'b0;
        wait_to(w + 70);
        push_ctl(0, cyc + 1, 0, 0, 0, "abort_wins");
        push_ctl(0, cyc + 3, 0, 0, 0, "abort_wins2");
        bus_b.start = 1'b1; bus_b.abort = 1'b1; tick();
        bus_b.start = 1'b0; bus_b.abort = 1'b0;
        repeat (4) tick();

        // asynchronous reset mid-HOLD
        bus_b.start = 1'b1; tick(); bus_b.start = 1'b0;
        w = cyc;
        wait_to(w + 4);
        pix(0, 411, 317, 1, "hold_px");
        tick();
        #2 rst = 1'b1;
        push_zero(0, cyc, "async_rst");
        repeat (2) tick();
        rst = 1'b0;
        push_ctl(0, cyc + 2, 0, 0, 0, "rst_stay_idle");
        push_ctl(0, cyc + 40, 0, 0, 0, "rst_need_start");
        repeat (60) tick();

        // forward-only sweep
        push_ctl(1, cyc, 0, 0, 0, "f_pre_start");
        bus_f.start = 1'b1; tick(); bus_f.start = 1'b0;
        w = cyc;
        for (int k = 0; k < 3; k++) begin
            push_ctl(1, w + 8 * k,     k, 1, 0, "f_step_first");
            push_ctl(1, w + 8 * k + 7, k, 1, 0, "f_step_last");
        end
        push_ctl(1, w + 24, 0, 0, 1, "f_done_cyc");
        push_ctl(1, w + 25, 0, 0, 0, "f_done_one");
        done_f.push_back(w + 24);
        wait_to(w + 20);
        pix(1, 609, 500, 1, "f_l2_hw2_left");
        wait_to(w + 30);

        end_req = 1'b1;
        repeat (3) tick();
    end

endmodule
